// File: rtl/timer_pkg.sv
// Shared encodings and default widths for the multi-channel interval timer.
package timer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int CNT_W_DEF = 16;
    localparam int PRE_W_DEF = 8;
    localparam int CH_MAX    = 16;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } tmr_state_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: counter, IDLE/RUN/DONE FSM, period latch and sticky IRQ flag.
// With MULTI_TIMER_PWM_EN it also latches a duty value and drives a registered PWM output.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             tick_i,
    input  logic             en_i,
    input  logic             cont_i,
    input  logic             irq_clr_i,
    input  logic [CNT_W-1:0] period_i,
`ifdef MULTI_TIMER_PWM_EN
    input  logic [CNT_W-1:0] duty_i,
    output logic             pwm_o,
`endif
    output logic             irq_o,
    output logic             active_o
);

    tmr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             irq_q, irq_d;
    logic             load;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        irq_d   = irq_q;
        load    = 1'b0;
        if (irq_clr_i) irq_d = 1'b0;
        if (!en_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
                S_RUN: begin
                    if (tick_i) begin
                        if (cnt_q == period_q) begin
                            // Set is assigned after clear so a coincident clear cannot drop the event.
                            cnt_d = '0;
                            irq_d = 1'b1;
                            load  = 1'b1;
                            if (!cont_i) state_d = S_DONE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    cnt_d = '0;
                    if (irq_clr_i) begin
                        state_d = S_RUN;
                        load    = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        period_d = load ? period_i : period_q;
    end

    // NOTE: asynchronous active-high reset sits in the sensitivity list; state uses <= only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_o    = irq_q;
    assign active_o = (state_q == S_RUN);

`ifdef MULTI_TIMER_PWM_EN
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             pwm_q;

    assign duty_d = load ? duty_i : duty_q;

    // PWM is computed from next-state values so it lines up with the registered count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= (state_d == S_RUN) && (cnt_d < duty_d);
        end
    end

    assign pwm_o = pwm_q;
`endif

endmodule

// File: rtl/multi_timer_core.sv
// N-channel interval timer: shared prescaler, CH timer_channel instances, registered IRQ OR.
// Optional PWM outputs are enabled by defining MULTI_TIMER_PWM_EN.
module multi_timer_core
    import timer_pkg::*;
#(
    parameter int CH    = 4,
    parameter int CNT_W = CNT_W_DEF,
    parameter int PRE_W = PRE_W_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [PRE_W-1:0]    i_prescale,
    input  logic [CH-1:0]       i_en,
    input  logic [CH-1:0]       i_cont,
    input  logic [CH-1:0]       i_irq_clr,
    input  logic [CH*CNT_W-1:0] i_period,
`ifdef MULTI_TIMER_PWM_EN
    input  logic [CH*CNT_W-1:0] i_duty,
    output logic [CH-1:0]       o_pwm,
`endif
    output logic [CH-1:0]       o_irq,
    output logic                o_irq_any,
    output logic [CH-1:0]       o_active
);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;
    logic             irq_any_q;

    // The prescaler is parked at zero whenever no channel is enabled.
    always_comb begin
        tick  = (|i_en) && (pre_q == i_prescale);
        pre_d = pre_q;
        if (!(|i_en) || tick) pre_d = '0;
        else                  pre_d = pre_q + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pre_q     <= '0;
            irq_any_q <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            irq_any_q <= |o_irq;
        end
    end

    assign o_irq_any = irq_any_q;

    for (genvar k = 0; k < CH; k++) begin : g_ch
        timer_channel #(.CNT_W(CNT_W)) u_ch (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .tick_i    (tick),
            .en_i      (i_en[k]),
            .cont_i    (i_cont[k]),
            .irq_clr_i (i_irq_clr[k]),
            .period_i  (i_period[k*CNT_W +: CNT_W]),
`ifdef MULTI_TIMER_PWM_EN
            .duty_i    (i_duty[k*CNT_W +: CNT_W]),
            .pwm_o     (o_pwm[k]),
`endif
            .irq_o     (o_irq[k]),
            .active_o  (o_active[k])
        );
    end

endmodule
